// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: op codes, flag bit positions,
// FSM state encoding and a small flag-packing helper.
package exec_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOT = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Assemble the {C, N, Z} register image from individual bits.
  function automatic logic [2:0] packFlags(input logic c, input logic n, input logic z);
    logic [2:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/exec_if.sv
// ID/EX -> EX -> EX/MEM handshake bundle. The master side is the
// decode/memory environment; the slave side is the execute stage.
interface exec_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
);
  import exec_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic              in_alu_src;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [DATA_W-1:0] in_imm;
  logic [TAG_W-1:0]  in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [TAG_W-1:0]  out_rd;
  logic [2:0]        flags;

  modport master (
    output in_valid, in_op, in_alu_src, in_a, in_b, in_imm, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd, flags
  );

  modport slave (
    input  in_valid, in_op, in_alu_src, in_a, in_b, in_imm, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd, flags
  );

endinterface

// File: rtl/exec_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W
// cycles per operation. 'last' is high during the cycle whose edge performs
// the final step; the full 2*DATA_W product then holds until the next start.
// Only instantiated when EXEC_MUL_EN is defined.
module exec_mul_seq #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  last,
  output logic [2*DATA_W-1:0]   product
);
  localparam int CNT_W = $clog2(DATA_W);

  logic                busy;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;

  assign last = busy && (cnt == CNT_W'(DATA_W - 1));

  // Latch operands on start, then accumulate one shifted multiplicand per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      cnt     <= '0;
      mcand   <= {{DATA_W{1'b0}}, a};
      mplier  <= b;
      product <= '0;
    end else if (busy) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (last) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: combinational ALU, registered EX/MEM result slot and the
// {C, N, Z} flag register. With EXEC_MUL_EN defined, op 7 runs on the
// iterative multiplier and holds off decode until the product is written;
// otherwise op 7 is a one-cycle NOP that forwards A and leaves flags alone.
module exec_stage
  import exec_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = $clog2(DATA_W),
  parameter int TAG_W   = 3
) (
  input  logic   clk,
  input  logic   rst,
  exec_if.slave  bus
);

  logic [DATA_W-1:0]  opB;
  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0]  aluRes;
  logic               aluC;
  logic               aluCWr;
  logic               aluFlagWr;

  logic               slotFree;
  logic               accept;
  logic               isMul;
  logic               wrAlu;
  logic               wrMul;
  logic [DATA_W-1:0]  mulRes;
  logic               mulC;
  logic [TAG_W-1:0]   mulRd;

  logic [DATA_W-1:0]  wrData;
  logic [TAG_W-1:0]   wrRd;
  logic [2:0]         flagsNxt;

  assign opB      = bus.in_alu_src ? bus.in_imm : bus.in_b;
  assign shamt    = opB[SHAMT_W-1:0];
  assign slotFree = !bus.out_valid || bus.out_ready;
  assign accept   = bus.in_valid && bus.in_ready;
  assign wrAlu    = accept && !isMul;

  // Single-cycle ALU; shifts widen by one bit so the last bit shifted out
  // falls into the carry position (and is 0 for a zero shift amount).
  always_comb begin
    aluRes    = '0;
    aluC      = 1'b0;
    aluCWr    = 1'b0;
    aluFlagWr = 1'b1;
    case (bus.in_op)
      OP_ADD: begin
        {aluC, aluRes} = {1'b0, bus.in_a} + {1'b0, opB};
        aluCWr = 1'b1;
      end
      OP_SUB: begin
        aluRes = bus.in_a - opB;
        aluC   = bus.in_a < opB;
        aluCWr = 1'b1;
      end
      OP_AND: aluRes = bus.in_a & opB;
      OP_OR:  aluRes = bus.in_a | opB;
      OP_NOT: aluRes = ~bus.in_a;
      OP_SHL: begin
        {aluC, aluRes} = {1'b0, bus.in_a} << shamt;
        aluCWr = 1'b1;
      end
      OP_SHR: begin
        {aluRes, aluC} = {bus.in_a, 1'b0} >> shamt;
        aluCWr = 1'b1;
      end
      default: begin
        // op 7 as NOP: forward A, no flag update
        aluRes    = bus.in_a;
        aluFlagWr = 1'b0;
      end
    endcase
  end

`ifdef EXEC_MUL_EN
  state_e              state;
  state_e              stateNxt;
  logic [2*DATA_W-1:0] product;
  logic                mulLast;

  assign isMul        = (bus.in_op == OP_MUL);
  assign bus.in_ready = (state == IDLE) && slotFree;
  assign wrMul        = (state == DONE) && slotFree;
  assign mulRes       = product[DATA_W-1:0];
  assign mulC         = |product[2*DATA_W-1:DATA_W];

  exec_mul_seq #(.DATA_W(DATA_W)) uMul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && isMul),
    .a       (bus.in_a),
    .b       (opB),
    .last    (mulLast),
    .product (product)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  // Next state: IDLE -> MUL on a multiply, MUL -> DONE after the last step,
  // DONE -> IDLE once the product can be written into the slot.
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (accept && isMul) stateNxt = MUL;
      MUL:     if (mulLast)         stateNxt = DONE;
      DONE:    if (slotFree)        stateNxt = IDLE;
      default:                      stateNxt = IDLE;
    endcase
  end

  // Destination tag travels with the multiply while it is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    mulRd <= '0;
    else if (accept && isMul)   mulRd <= bus.in_rd;
  end
`else
  assign isMul        = 1'b0;
  assign bus.in_ready = slotFree;
  assign wrMul        = 1'b0;
  assign mulRes       = '0;
  assign mulC         = 1'b0;
  assign mulRd        = '0;
`endif

  // Select what gets written into the slot and what the flags become;
  // ALU and multiply writes never coincide (ALU writes only from IDLE).
  always_comb begin
    wrData   = aluRes;
    wrRd     = bus.in_rd;
    flagsNxt = bus.flags;
    if (wrMul) begin
      wrData   = mulRes;
      wrRd     = mulRd;
      flagsNxt = packFlags(mulC, mulRes[DATA_W-1], mulRes == '0);
    end else if (wrAlu && aluFlagWr) begin
      flagsNxt = packFlags(aluCWr ? aluC : bus.flags[FLAG_C],
                           aluRes[DATA_W-1], aluRes == '0);
    end
  end

  // EX/MEM slot: a write replaces the contents (even while being consumed),
  // a consume without a write empties it, otherwise it holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_rd     <= '0;
    end else if (wrAlu || wrMul) begin
      bus.out_valid  <= 1'b1;
      bus.out_result <= wrData;
      bus.out_rd     <= wrRd;
    end else if (bus.out_ready) begin
      bus.out_valid  <= 1'b0;
    end
  end

  // Flag register; flagsNxt already equals the current value when nothing writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.flags <= '0;
    else     bus.flags <= flagsNxt;
  end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage. Honours EXEC_MUL_EN the same way as
// the design: multiply tests when defined, op 7 NOP test otherwise.
module tb_exec_stage;
  import exec_pkg::*;

  localparam int DATA_W  = 16;
  localparam int TAG_W   = 3;
  localparam int SHAMT_W = $clog2(DATA_W);

  typedef struct {
    logic [DATA_W-1:0] res;
    logic [TAG_W-1:0]  rd;
    logic [2:0]        flg;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   nAsserts = 0;
  int   nFail    = 0;
  exp_t expQ[$];
  logic [2:0] mFlags;

  exec_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  exec_stage #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference: operation semantics written with plain integer arithmetic.
  function automatic void refOp(input int op, input longint unsigned a, input longint unsigned b,
                                input logic [2:0] fin, output logic [DATA_W-1:0] res,
                                output logic [2:0] fout);
    longint unsigned full, mask;
    int  sh;
    logic c, wr;
    mask = (64'd1 << DATA_W) - 1;
    sh   = int'(b % DATA_W);
    c    = fin[2];
    wr   = 1'b1;
    full = 0;
    case (op)
      0: begin full = a + b; c = (full >> DATA_W) != 0; end
      1: begin full = (a + (mask + 1) - b); c = (a < b); end
      2: full = a & b;
      3: full = a | b;
      4: full = ~a;
      5: begin full = a << sh; c = (sh == 0) ? 1'b0 : 1'((a >> (DATA_W - sh)) & 1); end
      6: begin full = a >> sh; c = (sh == 0) ? 1'b0 : 1'((a >> (sh - 1)) & 1); end
      default: begin
`ifdef EXEC_MUL_EN
        full = a * b; c = (full >> DATA_W) != 0;
`else
        full = a; wr = 1'b0;
`endif
      end
    endcase
    full = full & mask;
    res  = full[DATA_W-1:0];
    fout = wr ? {c, res[DATA_W-1], res == '0} : fin;
  endfunction

  function automatic logic [DATA_W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return DATA_W'($urandom_range(0, DATA_W));
      default: return DATA_W'($urandom);
    endcase
  endfunction

  // Present one instruction with out_ready=1 and return #1 after its accept edge.
  task automatic issue(input logic [2:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic src, input logic [TAG_W-1:0] rd);
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_a       = a;
    bus.in_alu_src = src;
    bus.in_rd      = rd;
    bus.out_ready  = 1'b1;
    if (src) begin bus.in_imm = b; bus.in_b = ~b; end
    else     begin bus.in_b = b;   bus.in_imm = ~b; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    nAsserts++; if (bus.out_valid !== 1'b0) begin nFail++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    nAsserts++; if (bus.out_result !== '0) begin nFail++; $display("FAIL rst_out_result: got %h want 0", bus.out_result); end
    nAsserts++; if (bus.out_rd !== '0) begin nFail++; $display("FAIL rst_out_rd: got %h want 0", bus.out_rd); end
    nAsserts++; if (bus.flags !== 3'b000) begin nFail++; $display("FAIL rst_flags: got %b want 000", bus.flags); end
    nAsserts++; if (bus.in_ready !== 1'b1) begin nFail++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 3'd5);
    nAsserts++; if (bus.out_valid !== 1'b1) begin nFail++; $display("FAIL add_valid: got %b want 1", bus.out_valid); end
    nAsserts++; if (bus.out_result !== 16'h0000) begin nFail++; $display("FAIL add_result: got %h want 0000", bus.out_result); end
    nAsserts++; if (bus.out_rd !== 3'd5) begin nFail++; $display("FAIL add_rd: got %0d want 5", bus.out_rd); end
    nAsserts++; if (bus.flags !== 3'b101) begin nFail++; $display("FAIL add_flags: got %b want 101", bus.flags); end
  endtask

  task automatic test_sub_and();
    issue(OP_SUB, 16'h0003, 16'h0005, 1'b0, 3'd1);
    nAsserts++; if (bus.out_result !== 16'hFFFE) begin nFail++; $display("FAIL sub_result: got %h want fffe", bus.out_result); end
    nAsserts++; if (bus.flags !== 3'b110) begin nFail++; $display("FAIL sub_flags: got %b want 110", bus.flags); end
    issue(OP_AND, 16'hFFFF, 16'h0000, 1'b1, 3'd2);
    nAsserts++; if (bus.out_result !== 16'h0000) begin nFail++; $display("FAIL and_result: got %h want 0000", bus.out_result); end
    nAsserts++; if (bus.flags !== 3'b101) begin nFail++; $display("FAIL and_flags: got %b want 101", bus.flags); end
  endtask

  task automatic test_shift();
    issue(OP_SHL, 16'h8001, 16'h0001, 1'b0, 3'd3);
    nAsserts++; if (bus.out_result !== 16'h0002) begin nFail++; $display("FAIL shl_result: got %h want 0002", bus.out_result); end
    nAsserts++; if (bus.flags !== 3'b100) begin nFail++; $display("FAIL shl_flags: got %b want 100", bus.flags); end
    // only the low SHAMT_W bits of B count: 0x0010 is a zero shift
    issue(OP_SHR, 16'h1234, 16'h0010, 1'b1, 3'd4);
    nAsserts++; if (bus.out_result !== 16'h1234) begin nFail++; $display("FAIL shr0_result: got %h want 1234", bus.out_result); end
    nAsserts++; if (bus.flags !== 3'b000) begin nFail++; $display("FAIL shr0_flags: got %b want 000", bus.flags); end
    issue(OP_SHR, 16'h8003, 16'h0002, 1'b0, 3'd4);
    nAsserts++; if (bus.out_result !== 16'h2000 || bus.flags !== 3'b100) begin
      nFail++; $display("FAIL shr2: got %h/%b want 2000/100", bus.out_result, bus.flags); end
  endtask

  task automatic test_nop();
    issue(OP_SUB, 16'h0003, 16'h0005, 1'b0, 3'd0);
    issue(OP_MUL, 16'h0000, 16'h1234, 1'b0, 3'd7);
    nAsserts++; if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h0000 || bus.out_rd !== 3'd7) begin
      nFail++; $display("FAIL nop_slot: got %b/%h/%0d want 1/0000/7", bus.out_valid, bus.out_result, bus.out_rd); end
    nAsserts++; if (bus.flags !== 3'b110) begin nFail++; $display("FAIL nop_flags: got %b want 110", bus.flags); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] A[4] = '{16'hFFFF, 16'h7000, 16'h0100, 16'hFFFF};
    logic [DATA_W-1:0] B[4] = '{16'h0001, 16'h1000, 16'h0003, 16'hFFFF};
    logic [DATA_W-1:0] R[4] = '{16'h0000, 16'h8000, 16'h0103, 16'hFFFE};
    logic [2:0]        F[4] = '{3'b101, 3'b010, 3'b000, 3'b110};
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_op = OP_ADD; bus.in_alu_src = 1'b0;
    bus.in_a = A[0]; bus.in_b = B[0]; bus.in_rd = 3'd0;
    @(posedge clk); #1;
    bus.in_a = A[1]; bus.in_b = B[1]; bus.in_rd = 3'd1;
    for (int s = 0; s < 3; s++) begin
      nAsserts++; if (bus.in_ready !== 1'b0) begin nFail++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
      nAsserts++; if ({bus.out_valid, bus.out_result, bus.out_rd, bus.flags} !== {1'b1, R[0], 3'd0, F[0]}) begin
        nFail++; $display("FAIL bp_frozen: got %b/%h/%0d/%b want 1/%h/0/%b",
                          bus.out_valid, bus.out_result, bus.out_rd, bus.flags, R[0], F[0]); end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      #1;
      nAsserts++; if (bus.in_ready !== 1'b1) begin nFail++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
      @(posedge clk); #1;
      nAsserts++; if ({bus.out_valid, bus.out_result, bus.out_rd, bus.flags} !== {1'b1, R[k], 3'(k), F[k]}) begin
        nFail++; $display("FAIL bp_stream%0d: got %b/%h/%0d/%b want 1/%h/%0d/%b",
                          k, bus.out_valid, bus.out_result, bus.out_rd, bus.flags, R[k], k, F[k]); end
      if (k < 3) begin bus.in_a = A[k+1]; bus.in_b = B[k+1]; bus.in_rd = 3'(k + 1); end
      else bus.in_valid = 1'b0;
    end
    @(posedge clk); #1;
    nAsserts++; if (bus.out_valid !== 1'b0 || bus.flags !== F[3]) begin
      nFail++; $display("FAIL bp_drain: got %b/%b want 0/%b", bus.out_valid, bus.flags, F[3]); end
  endtask

  task automatic test_reset_mid();
    issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 3'd6);
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_op = OP_SUB;
    @(posedge clk); #1;
    nAsserts++; if (bus.out_valid !== 1'b1 || bus.flags !== 3'b101) begin
      nFail++; $display("FAIL pre_rst_state: got %b/%b want 1/101", bus.out_valid, bus.flags); end
    #2 rst = 1'b1;
    #1;
    nAsserts++; if (bus.out_valid !== 1'b0 || bus.flags !== 3'b000 || bus.in_ready !== 1'b1) begin
      nFail++; $display("FAIL mid_rst: got valid=%b flags=%b rdy=%b want 0/000/1", bus.out_valid, bus.flags, bus.in_ready); end
    @(negedge clk);
    rst = 1'b0; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    nAsserts++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      nFail++; $display("FAIL post_rst: got valid=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); end
    expQ.delete();
    mFlags = 3'b000;
  endtask

  task automatic test_random(input int n);
    logic expRdy;
    exp_t e;
    logic [DATA_W-1:0] bEff;
`ifdef EXEC_MUL_EN
    int maxOp = 6;
`else
    int maxOp = 7;
`endif
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.in_op      = 3'($urandom_range(0, maxOp));
      bus.in_a       = pick();
      bus.in_b       = pick();
      bus.in_imm     = pick();
      bus.in_alu_src = 1'($urandom_range(0, 1));
      bus.in_rd      = TAG_W'($urandom);
      #1;
      nAsserts++; if (bus.out_valid !== (expQ.size() != 0)) begin
        nFail++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, bus.out_valid, expQ.size() != 0); end
      if (expQ.size() != 0) begin
        nAsserts++; if ({bus.out_result, bus.out_rd, bus.flags} !== {expQ[0].res, expQ[0].rd, expQ[0].flg}) begin
          nFail++; $display("FAIL rnd_slot[%0d]: got %h/%0d/%b want %h/%0d/%b", i, bus.out_result,
                            bus.out_rd, bus.flags, expQ[0].res, expQ[0].rd, expQ[0].flg); end
      end else begin
        nAsserts++; if (bus.flags !== mFlags) begin
          nFail++; $display("FAIL rnd_flags[%0d]: got %b want %b", i, bus.flags, mFlags); end
      end
      expRdy = (expQ.size() == 0) || bus.out_ready;
      nAsserts++; if (bus.in_ready !== expRdy) begin
        nFail++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, bus.in_ready, expRdy); end
      if (bus.out_ready && expQ.size() != 0) void'(expQ.pop_front());
      if (bus.in_valid && expRdy) begin
        bEff = bus.in_alu_src ? bus.in_imm : bus.in_b;
        refOp(int'(bus.in_op), longint'(bus.in_a), longint'(bEff), mFlags, e.res, e.flg);
        e.rd   = bus.in_rd;
        mFlags = e.flg;
        expQ.push_back(e);
      end
    end
  endtask

`ifdef EXEC_MUL_EN
  // Count cycles with in_ready low, bounded so a stuck multiply cannot hang.
  task automatic waitMul(output int lowCnt);
    lowCnt = 0;
    for (int i = 0; i < 40 && bus.in_ready === 1'b0; i++) begin
      lowCnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul();
    int lowCnt, bad;
    logic [DATA_W-1:0] a, b, r;
    logic [2:0] f;
    logic src;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    issue(OP_MUL, 16'h0100, 16'h0100, 1'b0, 3'd3);
    waitMul(lowCnt);
    nAsserts++; if (lowCnt !== DATA_W + 1) begin nFail++; $display("FAIL mul_latency: got %0d want %0d", lowCnt, DATA_W + 1); end
    nAsserts++; if ({bus.out_valid, bus.out_result, bus.out_rd, bus.flags} !== {1'b1, 16'h0000, 3'd3, 3'b101}) begin
      nFail++; $display("FAIL mul_0100: got %b/%h/%0d/%b want 1/0000/3/101",
                        bus.out_valid, bus.out_result, bus.out_rd, bus.flags); end
    for (int k = 0; k < 4; k++) begin
      a = pick(); b = pick(); src = 1'($urandom_range(0, 1));
      refOp(7, longint'(a), longint'(b), 3'b000, r, f);
      issue(OP_MUL, a, b, src, 3'(k));
      waitMul(lowCnt);
      nAsserts++; if (lowCnt !== DATA_W + 1 || bus.out_result !== r || bus.out_rd !== 3'(k) || bus.flags !== f) begin
        nFail++; $display("FAIL mul_rnd%0d: got lat=%0d %h/%0d/%b want lat=%0d %h/%0d/%b", k, lowCnt,
                          bus.out_result, bus.out_rd, bus.flags, DATA_W + 1, r, k, f); end
    end
    issue(OP_MUL, 16'h00FF, 16'h0003, 1'b0, 3'd2);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    nAsserts++; if (bus.out_valid !== 1'b0 || bus.flags !== 3'b000) begin
      nFail++; $display("FAIL mul_rst: got %b/%b want 0/000", bus.out_valid, bus.flags); end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0 || bus.flags !== 3'b000) bad++;
    end
    nAsserts++; if (bad != 0) begin nFail++; $display("FAIL mul_abort: got %0d cycles with output want 0", bad); end
    nAsserts++; if (bus.in_ready !== 1'b1) begin nFail++; $display("FAIL mul_abort_ready: got %b want 1", bus.in_ready); end
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_alu_src = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_imm = '0; bus.in_rd = '0;
    bus.out_ready = 1'b0;
    rst    = 1'b1;
    mFlags = 3'b000;
    test_reset();
    test_add();
    test_sub_and();
    test_shift();
`ifndef EXEC_MUL_EN
    test_nop();
`endif
    test_backpressure();
    test_reset_mid();
    test_random(400);
`ifdef EXEC_MUL_EN
    test_mul();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
# exec_stage

Parametrised execute stage for the 5-stage pipeline: takes a decoded instruction from the ID/EX side, computes the ALU result, and updates a 3-bit condition-flag register. The result lands in a registered EX/MEM output slot governed by valid/ready handshakes. Single-cycle ALU ops complete in one cycle. An optional iterative multiplier occupies the stage for DATA_W cycles and back-pressures decode.

## Interface
- DATA_W, 16, operand/result width (≥4, power of two)
- SHAMT_W, $clog2(DATA_W), shift-amount bits taken from operand B
- TAG_W, 3, destination-register tag carried alongside the result
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  ID/EX holds a valid instruction
- in_ready  out  1  stage accepts this cycle (combinational)
- in_op  in  3  operation code
- in_alu_src  in  1  1: operand B = in_imm, 0: in_b
- in_a, in_b, in_imm  in  DATA_W  operands
- in_rd  in  TAG_W  destination tag, passed through
- out_valid  out  1  EX/MEM slot holds a result
- out_ready  in  1  MEM consumes the slot this cycle
- out_result  out  DATA_W  registered result
- out_rd  out  TAG_W  registered tag
- flags  out  3  {C, N, Z} register

## Operation
- Ops: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 NOT A, 5 SHL A by B[SHAMT_W-1:0], 6 SHR (logical), 7 MUL (low DATA_W bits of A×B).
- Arithmetic is modulo 2^DATA_W. ADD C = carry out. SUB C = borrow (A<B unsigned).
- SHL/SHR C = last bit shifted out. Shift amount 0 → result A, C=0.
- Z = result==0 and N = result[DATA_W-1], written for every op.
- C is written by ADD/SUB/SHL/SHR/MUL. AND/OR/NOT leave C unchanged.
- Flags update on the same edge the result is written into the output slot, never on an accept that does not write.
- Handshake: transfer when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
- out_valid/out_result/out_rd hold stable while out_valid && !out_ready.
- FSM:
  - IDLE: single-cycle op accepted → result written to slot; stay IDLE. MUL accepted → latch A, B; counter=0; go MUL.
  - MUL: one shift-add step per cycle. After step DATA_W-1 → DONE.
  - DONE: when !out_valid || out_ready → write product, update flags; go IDLE.
- MUL C = 1 iff the upper DATA_W bits of the full product are nonzero.
- Simultaneous consume and accept (out_valid && out_ready && in_valid in IDLE): the new result replaces the slot on the same edge; out_valid stays 1.
- out_ready with no new write clears out_valid.

## Timing
- Reset values: out_valid=0, out_result=0, out_rd=0, flags=3'b000, state=IDLE, counter=0. in_ready=1 right after reset.
- Single-cycle op latency: accepted at edge N → out_valid high after edge N (visible cycle N+1). Full throughput 1/cycle with out_ready=1.
- MUL latency: accepted at edge N → product written at edge N+DATA_W+1 if unstalled. in_ready=0 from edge N until the product is written.
- rst asserted mid-MUL aborts the operation immediately. No result and no flag change is produced.

## Configuration
- EXEC_MUL_EN defined: op 7 is the iterative multiply described above.
- EXEC_MUL_EN undefined: the multiplier and the MUL/DONE states are not built. Op 7 then completes in one cycle as a NOP: result = A, flags unchanged, out_valid still asserted.

## Structure
- Package exec_pkg holds:
  - op-code localparams (OP_ADD..OP_MUL)
  - flag bit indices (FLAG_Z=0, FLAG_N=1, FLAG_C=2)
  - FSM state enum (IDLE, MUL, DONE)
- Sub-module exec_mul_seq: the iterative shift-add multiplier with start/done. Instantiated only under EXEC_MUL_EN.
- Combinational ALU and the output slot live in exec_stage.

## Test plan
- Reset: rst pulsed mid-traffic → out_valid=0, flags=000, in_ready=1 next cycle.
- ADD 16'hFFFF+16'h0001, out_ready=1 → out_result=0000, flags Z=1 C=1 N=0 one cycle later.
- SUB 3−5 → out_result=FFFE, N=1, C=1. Following AND FFFF&0000 → Z=1, C stays 1.
- SHL A=8001, B=1 → out_result=0002, C=1. SHR with B=0 → out_result=A, C=0.
- Back-pressure: out_ready=0 with a back-to-back ADD stream → in_ready=0, slot and flags frozen. out_ready=1 → each queued op completes one per cycle with no loss or duplication.
- MUL (EXEC_MUL_EN) 0x0100×0x0100, DATA_W=16 → in_ready low for 17 cycles, out_result=0000, Z=1, C=1. rst in cycle 5 → no output produced.
